// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the MCU reset sequencer.
package mcu_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    PO_HOLD,
    SYS_HOLD,
    RUN
  } rst_state_e;

  localparam int unsigned CAUSE_POR    = 0;
  localparam int unsigned CAUSE_SYSREQ = 1;
  localparam int unsigned CAUSE_WDOG   = 2;
  localparam int unsigned CAUSE_LOCKUP = 3;
  localparam int unsigned CAUSE_EXT    = 4;
  localparam int unsigned CAUSE_W      = 5;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_rst_ctrl_if.sv
// Request/reset signal bundle between the reset sequencer and the MCU subsystem.
interface mcu_rst_ctrl_if import mcu_rst_pkg::*; ();

  logic               pll_locked;
  logic               ext_rst_req;
  logic               sysresetreq;
  logic               wdog_rst_req;
  logic               lockup;
  logic               rst_cause_clr;
  logic               poresetn;
  logic               hresetn;
  logic [CAUSE_W-1:0] rst_cause;
  logic               busy;

  modport master (
    output pll_locked, ext_rst_req, sysresetreq, wdog_rst_req, lockup, rst_cause_clr,
    input  poresetn, hresetn, rst_cause, busy
  );

  modport slave (
    input  pll_locked, ext_rst_req, sysresetreq, wdog_rst_req, lockup, rst_cause_clr,
    output poresetn, hresetn, rst_cause, busy
  );

endinterface

// File: rtl/rst_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input, cleared to 0 on reset.
module rst_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mcu_rst_ctrl.sv
// Reset sequencer: PLL lock qualification, ordered POR/system reset release,
// run-mode system reset requests and a sticky reset-cause register.
module mcu_rst_ctrl import mcu_rst_pkg::*; #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned LOCK_FILTER   = 4,
  parameter int unsigned POR_CYCLES    = 16,
  parameter int unsigned SYS_CYCLES    = 8,
  parameter bit          LOCKUP_RST_EN = 1'b1
) (
  input  logic         fpga_clk_in,
  input  logic         fpga_rst_in,
  mcu_rst_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = max3(LOCK_FILTER, POR_CYCLES, SYS_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_CYCLES - 1);

  if (SYNC_STAGES < 2 || LOCK_FILTER < 1 || POR_CYCLES < 1 || SYS_CYCLES < 1) begin : g_param_chk
    $error("mcu_rst_ctrl: parameter below minimum");
  end

  logic               w_lock;
  logic               w_ext;
  logic               w_lock_lost;
  logic [CAUSE_W-1:0] w_req_cause;
  logic [CAUSE_W-1:0] w_new_cause;

  rst_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_poresetn;
  logic               r_hresetn;
  logic               r_busy;
  logic [CAUSE_W-1:0] r_cause;

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .i_clk (fpga_clk_in),
    .i_rst (fpga_rst_in),
    .i_d   (bus.pll_locked),
    .o_q   (w_lock)
  );

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .i_clk (fpga_clk_in),
    .i_rst (fpga_rst_in),
    .i_d   (bus.ext_rst_req),
    .o_q   (w_ext)
  );

  // Requests are laid out directly in cause-bit positions so they can be ORed into rst_cause.
  always_comb begin
    w_req_cause               = '0;
    w_req_cause[CAUSE_SYSREQ] = bus.sysresetreq;
    w_req_cause[CAUSE_WDOG]   = bus.wdog_rst_req;
    w_req_cause[CAUSE_LOCKUP] = bus.lockup & LOCKUP_RST_EN;
    w_req_cause[CAUSE_EXT]    = w_ext;

    w_lock_lost = (r_state != WAIT_LOCK) && !w_lock;

    w_new_cause = '0;
    if (w_lock_lost) begin
      w_new_cause[CAUSE_POR] = 1'b1;
    end else if (r_state == RUN) begin
      w_new_cause = w_req_cause;
    end
  end

  always_ff @(posedge fpga_clk_in or posedge fpga_rst_in) begin
    if (fpga_rst_in) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_poresetn <= 1'b0;
      r_hresetn  <= 1'b0;
      r_busy     <= 1'b1;
      r_cause    <= CAUSE_W'(1);
    end else begin
      r_cause <= (bus.rst_cause_clr ? '0 : r_cause) | w_new_cause;

      if (w_lock_lost) begin
        r_state    <= WAIT_LOCK;
        r_cnt      <= '0;
        r_poresetn <= 1'b0;
        r_hresetn  <= 1'b0;
        r_busy     <= 1'b1;
      end else begin
        unique case (r_state)
          WAIT_LOCK: begin
            if (!w_lock) begin
              r_cnt <= '0;
            end else if (r_cnt == LOCK_LAST) begin
              r_state <= PO_HOLD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          PO_HOLD: begin
            if (r_cnt == POR_LAST) begin
              r_poresetn <= 1'b1;
              r_state    <= SYS_HOLD;
              r_cnt      <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          SYS_HOLD: begin
            if (r_cnt == SYS_LAST) begin
              r_hresetn <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= RUN;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          RUN: begin
            if (|w_req_cause) begin
              r_hresetn <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= SYS_HOLD;
              r_cnt     <= '0;
            end
          end

          default: begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.poresetn  = r_poresetn;
  assign bus.hresetn   = r_hresetn;
  assign bus.busy      = r_busy;
  assign bus.rst_cause = r_cause;

endmodule
